// File: rtl/valid_invalidator_pkg.sv
// Shared cache geometry, index type and invalidate FSM states.
// Imported by the valid-bit store and its interface.
package memory_sub_system_param;

  localparam int INDEX_LENGTH = 6;
  localparam int NUM_CACHE_LINES = 2**INDEX_LENGTH;

  typedef logic [INDEX_LENGTH-1:0] index_t;

  typedef enum logic [1:0] {
    IDLE,
    INV_ONE,
    FLUSH,
    DONE
  } inv_state_t;

endpackage

// File: rtl/valid_invalidator_if.sv
// Fill / lookup / invalidate bundle for the valid-bit store.
// flush_count exists only with VALID_INVALIDATOR_FLUSH_COUNT_EN.
interface valid_invalidator_if;
  import memory_sub_system_param::*;

  logic   fill_valid;
  index_t fill_index;
  logic   fill_ready;
  index_t lookup_index;
  logic   lookup_valid;
  logic   inv_req;
  logic   inv_all;
  index_t inv_index;
  logic   inv_ack;
  logic   busy;
`ifdef VALID_INVALIDATOR_FLUSH_COUNT_EN
  logic [15:0] flush_count;
`endif

  modport master (
    output fill_valid,
    output fill_index,
    input  fill_ready,
    output lookup_index,
    input  lookup_valid,
    output inv_req,
    output inv_all,
    output inv_index,
    input  inv_ack,
    input  busy
`ifdef VALID_INVALIDATOR_FLUSH_COUNT_EN
    , input flush_count
`endif
  );

  modport slave (
    input  fill_valid,
    input  fill_index,
    output fill_ready,
    input  lookup_index,
    output lookup_valid,
    input  inv_req,
    input  inv_all,
    input  inv_index,
    output inv_ack,
    output busy
`ifdef VALID_INVALIDATOR_FLUSH_COUNT_EN
    , output flush_count
`endif
  );

endinterface

// File: rtl/valid_invalidator.sv
// Valid-bit store with single-line invalidate and one-index-per-clock flush.
// Optional flush counter: VALID_INVALIDATOR_FLUSH_COUNT_EN.
module valid_invalidator
  import memory_sub_system_param::*;
(
  input logic              clk,
  input logic              resetn,
  valid_invalidator_if.slave bus
);

  localparam index_t LAST_IDX = index_t'(NUM_CACHE_LINES - 1);

  inv_state_t state_q, state_d;
  index_t     cnt_q, cnt_d;
  index_t     idx_q, idx_d;
  logic [NUM_CACHE_LINES-1:0] valid_q, valid_d;
  logic       lookup_valid_q, lookup_valid_d;
  logic       idle;

  assign idle = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    // Read old contents: lookups never see a same-cycle fill.
    lookup_valid_d = idle ? valid_q[bus.lookup_index] : 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.fill_valid) begin
          valid_d[bus.fill_index] = 1'b1;
        end
        if (bus.inv_req) begin
          idx_d   = bus.inv_index;
          state_d = bus.inv_all ? FLUSH : INV_ONE;
        end
      end
      INV_ONE: begin
        valid_d[idx_q] = 1'b0;
        state_d        = DONE;
      end
      FLUSH: begin
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      valid_q        <= '0;
      lookup_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      valid_q        <= valid_d;
      lookup_valid_q <= lookup_valid_d;
    end
  end

  assign bus.fill_ready   = idle;
  assign bus.busy         = !idle;
  assign bus.inv_ack      = (state_q == DONE);
  assign bus.lookup_valid = lookup_valid_q;

`ifdef VALID_INVALIDATOR_FLUSH_COUNT_EN
  logic [15:0] flush_count_q, flush_count_d;

  // Counted on the FLUSH->DONE step, so it shows in the ack cycle.
  always_comb begin
    flush_count_d = flush_count_q;
    if (state_q == FLUSH && state_d == DONE &&
        flush_count_q != 16'hFFFF) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      flush_count_q <= '0;
    end else begin
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_valid_invalidator.sv
// Directed bench for valid_invalidator: fills, lookups, invalidate, flush, reset.
// Flush-count checks build with VALID_INVALIDATOR_FLUSH_COUNT_EN.
module tb_valid_invalidator;
  import memory_sub_system_param::*;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  valid_invalidator_if bus ();

  valid_invalidator dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int idx);
    bus.fill_valid = 1'b1;
    bus.fill_index = index_t'(idx);
    tick();
    bus.fill_valid = 1'b0;
  endtask

  task automatic look(input string tag, input int idx,
                      input logic exp);
    bus.lookup_index = index_t'(idx);
    tick();
    chk(tag, {31'd0, bus.lookup_valid}, {31'd0, exp});
  endtask

`ifdef VALID_INVALIDATOR_FLUSH_COUNT_EN
  task automatic run_flush();
    logic got;
    got = 1'b0;
    bus.inv_req = 1'b1;
    bus.inv_all = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      tick();
      if (bus.inv_ack) got = 1'b1;
    end
    chk("flush_ack_seen", {31'd0, got}, 32'd1);
    bus.inv_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    resetn           = 1'b0;
    bus.fill_valid   = 1'b0;
    bus.fill_index   = '0;
    bus.lookup_index = '0;
    bus.inv_req      = 1'b0;
    bus.inv_all      = 1'b0;
    bus.inv_index    = '0;
    repeat (3) tick();

    chk("rst_fill_ready", {31'd0, bus.fill_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ack", {31'd0, bus.inv_ack}, 32'd0);
    chk("rst_lookup", {31'd0, bus.lookup_valid}, 32'd0);
`ifdef VALID_INVALIDATOR_FLUSH_COUNT_EN
    chk("rst_fcnt", {16'd0, bus.flush_count}, 32'd0);
`endif
    resetn = 1'b1;
    for (int i = 0; i < NUM_CACHE_LINES; i++) look("rst_sweep", i, 1'b0);

    // fill and lookup
    fill(5);
    look("fill5", 5, 1'b1);
    look("miss6", 6, 1'b0);
    bus.fill_valid   = 1'b1;
    bus.fill_index   = 6'd9;
    bus.lookup_index = 6'd9;
    tick();
    bus.fill_valid = 1'b0;
    chk("rbw9_old", {31'd0, bus.lookup_valid}, 32'd0);
    tick();
    chk("rbw9_new", {31'd0, bus.lookup_valid}, 32'd1);

    // single-line invalidate
    fill(3);
    fill(7);
    bus.inv_req   = 1'b1;
    bus.inv_all   = 1'b0;
    bus.inv_index = 6'd3;
    chk("one_T_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("one_T1_busy", {31'd0, bus.busy}, 32'd1);
    chk("one_T1_ack", {31'd0, bus.inv_ack}, 32'd0);
    chk("one_T1_frdy", {31'd0, bus.fill_ready}, 32'd0);
    bus.lookup_index = 6'd7;
    tick();
    chk("one_T2_ack", {31'd0, bus.inv_ack}, 32'd1);
    chk("one_T2_miss", {31'd0, bus.lookup_valid}, 32'd0);
    bus.inv_req = 1'b0;
    tick();
    chk("one_T3_ack", {31'd0, bus.inv_ack}, 32'd0);
    chk("one_T3_busy", {31'd0, bus.busy}, 32'd0);
    look("one_3", 3, 1'b0);
    look("one_7", 7, 1'b1);

    // whole-cache flush, fill during busy is dropped
    fill(0);
    fill(31);
    fill(63);
    bus.inv_req = 1'b1;
    bus.inv_all = 1'b1;
    for (int k = 1; k <= NUM_CACHE_LINES + 1; k++) begin
      tick();
      chk("fl_busy", {31'd0, bus.busy}, 32'd1);
      chk("fl_ack", {31'd0, bus.inv_ack},
          {31'd0, k == NUM_CACHE_LINES + 1});
      if (k == 10) begin
        bus.fill_valid = 1'b1;
        bus.fill_index = 6'd40;
      end
      if (k == 11) bus.fill_valid = 1'b0;
      if (k == NUM_CACHE_LINES + 1) bus.inv_req = 1'b0;
    end
    tick();
    chk("fl_idle", {31'd0, bus.busy}, 32'd0);
    chk("fl_ack_end", {31'd0, bus.inv_ack}, 32'd0);
`ifdef VALID_INVALIDATOR_FLUSH_COUNT_EN
    chk("fl_fcnt1", {16'd0, bus.flush_count}, 32'd1);
`endif
    for (int i = 0; i < NUM_CACHE_LINES; i++) look("fl_sweep", i, 1'b0);

    // fill and invalidate of the same line in one cycle
    bus.fill_valid = 1'b1;
    bus.fill_index = 6'd12;
    bus.inv_req    = 1'b1;
    bus.inv_all    = 1'b0;
    bus.inv_index  = 6'd12;
    tick();
    bus.fill_valid = 1'b0;
    tick();
    chk("same12_ack", {31'd0, bus.inv_ack}, 32'd1);
    bus.inv_req = 1'b0;
    tick();
    look("same12", 12, 1'b0);
`ifdef VALID_INVALIDATOR_FLUSH_COUNT_EN
    chk("one_nocnt", {16'd0, bus.flush_count}, 32'd1);
`endif

    // reset in the middle of a flush
    fill(50);
    bus.inv_req = 1'b1;
    bus.inv_all = 1'b1;
    repeat (20) tick();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    resetn      = 1'b0;
    bus.inv_req = 1'b0;
    bus.inv_all = 1'b0;
    tick();
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst_ack", {31'd0, bus.inv_ack}, 32'd0);
    chk("mrst_frdy", {31'd0, bus.fill_ready}, 32'd1);
`ifdef VALID_INVALIDATOR_FLUSH_COUNT_EN
    chk("mrst_fcnt", {16'd0, bus.flush_count}, 32'd0);
`endif
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_ack", {31'd0, bus.inv_ack}, 32'd0);
    end
    look("mrst_50", 50, 1'b0);
    look("mrst_5", 5, 1'b0);
    look("mrst_7", 7, 1'b0);

`ifdef VALID_INVALIDATOR_FLUSH_COUNT_EN
    run_flush();
    run_flush();
    run_flush();
    chk("fcnt3", {16'd0, bus.flush_count}, 32'd3);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("fcnt_rst", {16'd0, bus.flush_count}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/valid_invalidator.md
Name: valid_invalidator

Overview:
- Valid-bit store for the direct-mapped cache, with the clearing side of the protocol added.
- Fills set a line's valid bit. The invalidate engine clears either one line or all lines, using a req/ack handshake.
- A whole-cache flush walks one index per clock, so the storage stays SRAM-mappable.
- Sits beside the tag/data memories and is driven by the cache controller (fills, lookups) and by the coherence/flush logic (invalidates).

Parameters:
INDEX_LENGTH, 6, index width in bits (taken from memory_sub_system_param).
NUM_CACHE_LINES, 2**INDEX_LENGTH, number of valid bits / cache lines.

Ports:
clk  input  1  clock.
resetn  input  1  synchronous, active-low reset.
fill_valid  input  1  set valid bit at fill_index this cycle.
fill_index  input  INDEX_LENGTH  line being filled.
fill_ready  output  1  fill accepted; high only in IDLE.
lookup_index  input  INDEX_LENGTH  line being queried.
lookup_valid  output  1  registered valid bit of lookup_index.
inv_req  input  1  invalidate request; held high until inv_ack.
inv_all  input  1  1 = flush all lines, 0 = single line; sampled at acceptance.
inv_index  input  INDEX_LENGTH  line to clear when inv_all=0; sampled at acceptance.
inv_ack  output  1  one-cycle completion pulse.
busy  output  1  engine not in IDLE.

Behaviour:
- Reset (clk, resetn synchronous active-low):
  - All valid bits cleared; state IDLE; walk counter 0.
  - lookup_valid=0, inv_ack=0, busy=0, fill_ready=1 (combinational from IDLE).
- Reset mid-operation: same result; any in-flight invalidate is abandoned and no ack is issued.
- States:
  - IDLE: fill_ready=1, busy=0.
    - If inv_req=1, latch inv_all and inv_index; go to INV_ONE (inv_all=0) or FLUSH (inv_all=1).
  - INV_ONE: clear valid[latched index]; go to DONE.
  - FLUSH:
    - Clear valid[cnt]; cnt increments.
    - On cnt=NUM_CACHE_LINES-1, clear that bit, reset cnt to 0, go to DONE.
    - Takes exactly NUM_CACHE_LINES cycles.
  - DONE: inv_ack=1 (registered, single cycle); go to IDLE.
- Latency, with acceptance at cycle T:
  - Single invalidate: bit cleared at T+1 edge; inv_ack high in cycle T+2.
  - Flush: bits 0..N-1 cleared in cycles T+1..T+N; inv_ack in cycle T+N+1.
- Handshake:
  - Requester holds inv_req and its qualifiers until inv_ack and drops inv_req in the ack cycle.
  - inv_req still high in the cycle after ack is a new request, accepted in IDLE.
- Fill:
  - Applied only when fill_valid && fill_ready; fill_valid while busy is ignored (not queued).
  - Fill and inv_req in the same IDLE cycle: the fill is applied, then the invalidate is processed. Same index ends invalid (invalidate wins by ordering).
- Lookup:
  - lookup_valid <= valid[lookup_index] when IDLE, else 0. This forces a miss during any invalidate.
  - Read-before-write: a fill and a lookup to the same index in one cycle return the old value.
- busy = (state != IDLE).
- Counter width is INDEX_LENGTH; wrap to 0 is the flush exit condition.

Optional Feature:
- Macro VALID_INVALIDATOR_FLUSH_COUNT_EN.
- Defined:
  - Adds output flush_count [15:0].
  - Increments by one on each DONE reached from FLUSH; saturates at 16'hFFFF; reset to 0.
  - Single-line invalidates are not counted.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- memory_sub_system_param holds INDEX_LENGTH and NUM_CACHE_LINES.
- Add to the same package: typedef index_t (logic [INDEX_LENGTH-1:0]) and typedef enum inv_state_t {IDLE, INV_ONE, FLUSH, DONE}.
- No sub-module. The FSM, walk counter and bit array stay in one module.

Test Plan:
- Reset, then lookup all 64 indices -> lookup_valid=0 for each, one cycle after index applied; fill_ready=1, busy=0.
- Fill index 5, lookup 5 next cycle -> lookup_valid=1; lookup 6 -> 0; same-cycle fill+lookup of 9 -> 0, then 1 next cycle.
- Fill 3 and 7; inv_req, inv_all=0, inv_index=3 at T -> busy at T+1, inv_ack at T+2 only; afterwards lookup 3=0, 7=1.
- Fill 0, 31, 63; flush at T -> busy T+1..T+65, inv_ack pulse at T+65, fill_valid during busy ignored; after flush all lookups=0.
- Fill index 12 and inv_req (inv_all=0, inv_index=12) in the same IDLE cycle -> line 12 invalid after ack.
- Reset asserted at T+20 of a flush -> next cycle state IDLE, all bits 0, no inv_ack. With VALID_INVALIDATOR_FLUSH_COUNT_EN, three completed flushes -> flush_count=3, and reset returns it to 0.
